// File: rtl/jk_pkg.sv
// Definitions shared by jk_bank_writer and the JK flop bank it drives:
// per-flop command encodings and the writer's FSM states.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } jk_state_e;

endpackage

// File: rtl/jk_lsb_find.sv
// Combinational priority encoder: index of the lowest set bit of i_vec,
// plus a flag that says whether any bit is set (index is 0 when none is).
module jk_lsb_find #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    // Scan high to low so the lowest set bit is the last assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
    o_any = |i_vec;
  end

endmodule

// File: rtl/jk_bank_writer.sv
// Drives a shared JK command bus: snapshots the bank against a masked target
// word and issues one command per cycle for each bit that must change.
module jk_bank_writer
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int USE_TOGGLE = 1,
  parameter int FAST       = 0,
  localparam int IW        = $clog2(WIDTH),
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q_in,
  output logic             cmd_valid,
  output logic [IW-1:0]    cmd_idx,
  output logic [1:0]       cmd_state,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    n_issued
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is only high in IDLE.

  jk_state_e        r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_idx;
  logic             r_cmd_valid;
  logic [IW-1:0]    r_cmd_idx;
  logic [1:0]       r_cmd_state;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
  logic [CW-1:0]    r_n_issued;

  jk_state_e        w_nxt_state;
  logic [WIDTH-1:0] w_nxt_diff;
  logic [CW-1:0]    w_nxt_idx;
  logic             w_accept;
  logic             w_scan;
  logic             w_issue;
  logic [IW-1:0]    w_issue_idx;
  logic [1:0]       w_issue_state;
  logic [WIDTH-1:0] w_new_diff;
  logic [WIDTH-1:0] w_cur_diff;
  logic [WIDTH-1:0] w_cur_data;
  logic [CW-1:0]    w_cur_idx;
  logic [IW-1:0]    w_lsb_idx;
  logic             w_lsb_any;

  assign w_accept   = req_valid && r_ready && (r_state == IDLE);
  assign w_new_diff = req_mask & (q_in ^ req_data);
  // On the accept edge the first command comes from the fresh snapshot.
  assign w_cur_diff = w_accept ? w_new_diff : r_diff;
  assign w_cur_data = w_accept ? req_data   : r_data;
  assign w_cur_idx  = w_accept ? '0         : r_idx;

  generate
    if (FAST != 0) begin : g_fast
      jk_lsb_find #(.WIDTH(WIDTH), .IW(IW)) u_lsb (
        .i_vec (w_cur_diff),
        .o_idx (w_lsb_idx),
        .o_any (w_lsb_any)
      );
    end else begin : g_slow
      assign w_lsb_idx = '0;
      assign w_lsb_any = 1'b0;
    end
  endgenerate

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_diff    = r_diff;
    w_nxt_idx     = r_idx;
    w_scan        = 1'b0;
    w_issue       = 1'b0;
    w_issue_idx   = '0;
    w_issue_state = JK_HOLD;
    case (r_state)
      IDLE: if (w_accept) begin
        w_nxt_diff = w_new_diff;
        w_nxt_idx  = '0;
        w_scan     = 1'b1;
      end
      SCAN: w_scan = 1'b1;
      DONE: w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
    if (w_scan) begin
      if (FAST == 0) begin
        if (w_cur_idx == CW'(WIDTH)) begin
          w_nxt_state = DONE;
        end else begin
          w_issue_idx = w_cur_idx[IW-1:0];
          w_issue     = w_cur_diff[w_issue_idx];
          w_nxt_idx   = w_cur_idx + CW'(1);
          w_nxt_state = SCAN;
        end
      end else begin
        if (!w_lsb_any) begin
          w_nxt_state = DONE;
        end else begin
          w_issue     = 1'b1;
          w_issue_idx = w_lsb_idx;
          w_nxt_diff  = w_cur_diff & ~(WIDTH'(1) << w_lsb_idx);
          w_nxt_state = SCAN;
        end
      end
    end
    if (w_issue) begin
      if (USE_TOGGLE != 0) w_issue_state = JK_TOGGLE;
      else                 w_issue_state = w_cur_data[w_issue_idx] ? JK_SET : JK_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_diff      <= '0;
      r_idx       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_idx   <= '0;
      r_cmd_state <= JK_HOLD;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b0;
      r_n_issued  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_diff      <= w_nxt_diff;
      r_idx       <= w_nxt_idx;
      r_cmd_valid <= w_issue;
      r_cmd_idx   <= (w_nxt_state == SCAN) ? w_issue_idx : '0;
      r_cmd_state <= w_issue_state;
      r_busy      <= (w_nxt_state != IDLE);
      r_done      <= (w_nxt_state == DONE);
      r_ready     <= (w_nxt_state == IDLE);
      if (w_accept) begin
        r_data     <= req_data;
        r_n_issued <= w_issue ? CW'(1) : '0;
      end else if (w_issue) begin
        r_n_issued <= r_n_issued + CW'(1);
      end
    end
  end

  assign req_ready = r_ready;
  assign cmd_valid = r_cmd_valid;
  assign cmd_idx   = r_cmd_idx;
  assign cmd_state = r_cmd_state;
  assign busy      = r_busy;
  assign done      = r_done;
  assign n_issued  = r_n_issued;

endmodule

// File: tb/tb_jk_bank_writer.sv
// Directed bench for jk_bank_writer: three instances cover fixed scan with
// set/reset, fixed scan with toggle, and the fast lowest-bit-first walk.
module tb_jk_bank_writer;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  req_data;
  logic [W-1:0]  req_mask;
  logic [W-1:0]  q_in;
  logic          v0, v1, v2;
  logic          rdy0, rdy1, rdy2;
  logic          cv0, cv1, cv2;
  logic [IW-1:0] ci0, ci1, ci2;
  logic [1:0]    cs0, cs1, cs2;
  logic          bz0, bz1, bz2;
  logic          dn0, dn1, dn2;
  logic [CW-1:0] ni0, ni1, ni2;

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  jk_bank_writer #(.WIDTH(W), .USE_TOGGLE(0), .FAST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
    .req_data(req_data), .req_mask(req_mask), .q_in(q_in),
    .cmd_valid(cv0), .cmd_idx(ci0), .cmd_state(cs0),
    .busy(bz0), .done(dn0), .n_issued(ni0)
  );

  jk_bank_writer #(.WIDTH(W), .USE_TOGGLE(1), .FAST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_data(req_data), .req_mask(req_mask), .q_in(q_in),
    .cmd_valid(cv1), .cmd_idx(ci1), .cmd_state(cs1),
    .busy(bz1), .done(dn1), .n_issued(ni1)
  );

  jk_bank_writer #(.WIDTH(W), .USE_TOGGLE(0), .FAST(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
    .req_data(req_data), .req_mask(req_mask), .q_in(q_in),
    .cmd_valid(cv2), .cmd_idx(ci2), .cmd_state(cs2),
    .busy(bz2), .done(dn2), .n_issued(ni2)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] m);
    q_in     = q;
    req_data = d;
    req_mask = m;
  endtask

  // dut0, q=00 data=A5 mask=FF; optional disturbance of the inputs mid-scan.
  task automatic run_a5_dut0(input bit disturb);
    logic [W-1:0] pat;
    int exp_n;
    pat = 8'hA5;
    exp_n = 0;
    set_req(8'h00, 8'hA5, 8'hFF);
    v0 = 1'b1;
    check("a5_ready_before", rdy0, 1);
    tick();
    v0 = 1'b0;
    for (int c = 1; c <= W; c++) begin
      if (pat[c-1]) exp_n++;
      check($sformatf("a5_valid_c%0d", c), cv0, pat[c-1]);
      check($sformatf("a5_state_c%0d", c), cs0, pat[c-1] ? 2'b10 : 2'b00);
      if (pat[c-1]) check($sformatf("a5_idx_c%0d", c), ci0, c - 1);
      check($sformatf("a5_n_c%0d", c), ni0, exp_n);
      check($sformatf("a5_busy_c%0d", c), bz0, 1);
      check($sformatf("a5_done_c%0d", c), dn0, 0);
      check($sformatf("a5_ready_c%0d", c), rdy0, 0);
      if (disturb && c == 4) begin
        v0 = 1'b1;
        set_req(8'hFF, 8'h00, 8'hFF);
      end
      if (disturb && c == 8) v0 = 1'b0;
      tick();
    end
    check("a5_done_c9", dn0, 1);
    check("a5_valid_c9", cv0, 0);
    check("a5_n_final", ni0, 4);
    tick();
    check("a5_idle_ready", rdy0, 1);
    check("a5_idle_busy", bz0, 0);
    check("a5_idle_done", dn0, 0);
    check("a5_n_hold", ni0, 4);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [W-1:0] bank;
    logic [W-1:0] diff;
    logic [W-1:0] exp_cmd;
    n_checks = 0;
    n_errors = 0;

    // Reset with requests pending
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    set_req(8'h00, 8'hA5, 8'hFF);
    tick();
    tick();
    check("rst_ready0", rdy0, 0);
    check("rst_valid0", cv0, 0);
    check("rst_state0", cs0, 0);
    check("rst_busy0", bz0, 0);
    check("rst_done0", dn0, 0);
    check("rst_n0", ni0, 0);
    check("rst_ready2", rdy2, 0);
    check("rst_busy2", bz2, 0);
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    tick();
    check("rel_ready0", rdy0, 1);
    check("rel_ready1", rdy1, 1);
    check("rel_ready2", rdy2, 1);
    check("rel_busy0", bz0, 0);

    // Fixed scan, set/reset
    run_a5_dut0(1'b0);

    // Fixed scan, toggle, against a flop-bank model
    set_req(8'hF0, 8'h0F, 8'h3C);
    bank = 8'hF0;
    diff = 8'h3C;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int c = 1; c <= W; c++) begin
      check($sformatf("tg_valid_c%0d", c), cv1, diff[c-1]);
      check($sformatf("tg_state_c%0d", c), cs1, diff[c-1] ? 2'b11 : 2'b00);
      if (cv1) begin
        if (cs1 == 2'b11) bank[ci1] = ~bank[ci1];
        else if (cs1 == 2'b10) bank[ci1] = 1'b1;
        else if (cs1 == 2'b01) bank[ci1] = 1'b0;
      end
      tick();
    end
    check("tg_done", dn1, 1);
    check("tg_n", ni1, 4);
    check("tg_bank", bank, 8'hCC);
    tick();
    check("tg_ready_after", rdy1, 1);

    // Fast walk: reset bits 0 and 7
    set_req(8'h81, 8'h00, 8'hFF);
    exp_q.push_back({3'd0, 2'b01, 3'b000});
    exp_q.push_back({3'd7, 2'b01, 3'b000});
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      check($sformatf("fa_valid_c%0d", c), cv2, 1);
      exp_cmd = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
      check($sformatf("fa_cmd_c%0d", c), {ci2, cs2, 3'b000}, exp_cmd);
      check($sformatf("fa_done_c%0d", c), dn2, 0);
      tick();
    end
    check("fa_done_c3", dn2, 1);
    check("fa_valid_c3", cv2, 0);
    check("fa_n", ni2, 2);
    check("fa_q_empty", exp_q.size(), 0);
    tick();
    check("fa_ready_c4", rdy2, 1);

    // Fast walk with no differing bits, back-to-back accepts
    set_req(8'h3C, 8'h3C, 8'hFF);
    v2 = 1'b1;
    tick();
    check("z_done_c1", dn2, 1);
    check("z_valid_c1", cv2, 0);
    check("z_n_c1", ni2, 0);
    check("z_ready_c1", rdy2, 0);
    tick();
    check("z_ready_c2", rdy2, 1);
    check("z_done_c2", dn2, 0);
    check("z_busy_c2", bz2, 0);
    tick();
    v2 = 1'b0;
    check("z2_done", dn2, 1);
    check("z2_busy", bz2, 1);
    tick();

    // Reset in the middle of a fixed scan
    set_req(8'h00, 8'hA5, 8'hFF);
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    check("ab_valid_c1", cv0, 1);
    tick();
    v0 = 1'b1;
    check("ab_ready_c2", rdy0, 0);
    tick();
    check("ab_ready_c3", rdy0, 0);
    rst_n = 1'b0;
    tick();
    check("ab_valid", cv0, 0);
    check("ab_busy", bz0, 0);
    check("ab_done", dn0, 0);
    check("ab_n", ni0, 0);
    check("ab_ready", rdy0, 0);
    rst_n = 1'b1;
    v0 = 1'b0;
    tick();
    check("ab_rel_ready", rdy0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("ab_no_done_%0d", c), dn0, 0);
      check($sformatf("ab_idle_busy_%0d", c), bz0, 0);
    end

    // Normal run after reset, with a request and input churn mid-scan
    run_a5_dut0(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
